// File: rtl/schoolbook_ctrl_if.sv
// Stream bundle between the bus adapter and schoolbook_ctrl:
// an operand word stream into the controller and a product word stream out of it.
interface schoolbook_ctrl_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  // Bus adapter side: produces operand words, consumes product words.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/schoolbook_ctrl.sv
// Word-serial front/back end for the iterative schoolbook multiplier.
// Collects operands a and b as W-bit words and holds them on the core inputs.
// Clears the core, waits out its fixed latency, then streams the 2N-bit
// product back as W-bit words, least-significant word first.
module schoolbook_ctrl #(
  parameter int unsigned N   = 163,
  parameter int unsigned W   = 32,
  parameter int unsigned LAT = 165
) (
  input  logic             clk,
  input  logic             rst,
  schoolbook_ctrl_if.slave bus,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  output logic             mul_rst,
  input  logic [2*N-1:0]   mul_c,
  output logic             busy
);
  localparam int unsigned NW   = (N + W - 1) / W;
  localparam int unsigned NP   = (2 * N + W - 1) / W;
  localparam int unsigned WC_W = $clog2(2 * NW);
  localparam int unsigned LC_W = $clog2(LAT + 1);

  localparam logic [WC_W-1:0] NW_C      = WC_W'(NW);
  localparam logic [WC_W-1:0] IN_LAST   = WC_W'(2 * NW - 1);
  localparam logic [WC_W-1:0] OUT_LAST  = WC_W'(NP - 1);
  localparam logic [LC_W-1:0] WAIT_LAST = LC_W'(LAT - 1);
  localparam logic [NW*W-1:0] WORD_MASK = {{(NW*W-W){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {
    S_LOAD,
    S_CLR,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state, state_d;
  logic [WC_W-1:0] wcnt;      // operand word counter in LOAD, product word index in OUT
  logic [LC_W-1:0] wait_cnt;
  logic [N-1:0]    a_q, b_q, a_d, b_d;
  logic [N-1:0]    rep, mask;
  logic [WC_W-1:0] slot;
  logic            a_sel;
  logic [2*N-1:0]  prod_q;

  // Merge the incoming word into its operand slice; the word is replicated
  // across the operand width and a shifted mask picks the slice, so bits of
  // the top word beyond N-1 fall away in the truncation.
  always_comb begin
    a_sel = (wcnt < NW_C);
    slot  = a_sel ? wcnt : wcnt - NW_C;
    rep   = N'({NW{bus.in_data}});
    mask  = N'(WORD_MASK << (slot * W));
    a_d   = a_sel ? ((a_q & ~mask) | (rep & mask)) : a_q;
    b_d   = a_sel ? b_q : ((b_q & ~mask) | (rep & mask));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_d;
    end
  end

  // Next state and handshake/control outputs decoded from the current state.
  always_comb begin
    state_d       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    mul_rst       = 1'b0;
    busy          = 1'b1;
    case (state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid && wcnt == IN_LAST) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        mul_rst = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (wcnt == OUT_LAST);
        if (bus.out_ready && wcnt == OUT_LAST) begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Operand loading, latency counting, product capture and word indexing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wait_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (bus.in_valid) begin
            a_q  <= a_d;
            b_q  <= b_d;
            wcnt <= (wcnt == IN_LAST) ? '0 : wcnt + 1'b1;
          end
        end
        S_CLR: begin
          wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            prod_q <= mul_c;
            wcnt   <= '0;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            wcnt <= (wcnt == OUT_LAST) ? '0 : wcnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign bus.out_data = W'(prod_q >> (wcnt * W));

endmodule

// File: tb/tb_schoolbook_ctrl.sv
// Self-checking bench for schoolbook_ctrl with a behavioural stand-in for the
// multiplier core and a product-level scoreboard.
module tb_schoolbook_ctrl;
  localparam int unsigned N   = 163;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 165;
  localparam int unsigned NW  = 6;
  localparam int unsigned NP  = 11;
  localparam int unsigned PW  = NP * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  schoolbook_ctrl_if #(.W(W)) bus ();

  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_rst;
  logic [2*N-1:0] mul_c;
  logic           busy;

  schoolbook_ctrl #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_rst (mul_rst),
    .mul_c   (mul_c),
    .busy    (busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Core stand-in: held cleared while mul_rst=0; shows a wrong value until its
  // N+1-th enabled edge, then the true product.
  int unsigned    core_cnt = 0;
  logic [2*N-1:0] core_prod;
  assign core_prod = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
  always @(posedge clk) begin
    if (!mul_rst) begin
      core_cnt <= 0;
      mul_c    <= '0;
    end else begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 < N + 1) mul_c <= ~core_prod;
      else if (core_cnt + 1 == N + 1) mul_c <= core_prod;
    end
  end

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] cur = '0;
  logic [W-1:0]  prev_data = '0;
  logic [W-1:0]  exp_word;
  int unsigned   out_idx = 0;
  int unsigned   done_cnt = 0;
  int unsigned   e_cyc = 0;
  int unsigned   stall_mode = 0;
  bit            first_pending = 1'b0;
  bit            prev_stall = 1'b0;
  bit            prev_last_hs = 1'b0;

  // out_ready: always high, or random stalls.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (stall_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        out_idx = 0; first_pending = 1'b0; prev_stall = 1'b0; prev_last_hs = 1'b0; cur = '0;
      end else begin
        chk("busy_vs_in_ready", PW'(busy), PW'(!bus.in_ready));
        chk("in_out_exclusive", PW'(bus.in_ready & bus.out_valid), '0);
        if (mul_rst) chk("clear_released_only_in_wait", PW'({bus.in_ready, bus.out_valid}), '0);
        if (prev_last_hs) chk("in_ready_after_last", PW'(bus.in_ready), PW'(1'b1));
        if (prev_stall) begin
          chk("stall_valid_held", PW'(bus.out_valid), PW'(1'b1));
          chk("stall_data_held", PW'(bus.out_data), PW'(prev_data));
        end
        prev_last_hs = 1'b0;
        prev_stall   = 1'b0;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
          end else begin
            exp_word = W'(exp_q[0] >> (out_idx * W));
            if (first_pending && out_idx == 0) begin
              chk("first_valid_latency", PW'(cyc - e_cyc), PW'(LAT + 1));
              first_pending = 1'b0;
            end
            chk("out_data", PW'(bus.out_data), PW'(exp_word));
            chk("out_last", PW'(bus.out_last), PW'(out_idx == NP - 1));
            if (bus.out_ready) begin
              cur[out_idx*W +: W] = bus.out_data;
              out_idx++;
              if (out_idx == NP) begin
                got_q.push_back(cur);
                void'(exp_q.pop_front());
                cur = '0; out_idx = 0; done_cnt++; prev_last_hs = 1'b1;
              end
            end else begin
              prev_stall = 1'b1;
              prev_data  = bus.out_data;
            end
          end
        end else begin
          chk("out_last_without_valid", PW'(bus.out_last), '0);
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] w, input int unsigned gap);
    bit hs;
    int unsigned n = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    forever begin
      hs = bus.in_ready;
      @(posedge clk); #1;
      if (hs) break;
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout actual=0 required=1");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic load_op(input logic [NW*W-1:0] aw, input logic [NW*W-1:0] bw, input bit gaps);
    logic [2*NW*W-1:0] words;
    logic [PW-1:0] ea, eb;
    words = {bw, aw};
    for (int k = 0; k < 2 * NW; k++) send_word(words[k*W +: W], gaps ? $urandom_range(0, 3) : 0);
    e_cyc = cyc;
    first_pending = 1'b1;
    ea = '0; eb = '0;
    ea[N-1:0] = aw[N-1:0];
    eb[N-1:0] = bw[N-1:0];
    exp_q.push_back(ea * eb);
    chk("mul_a_loaded", PW'(mul_a), PW'(aw[N-1:0]));
    chk("mul_b_loaded", PW'(mul_b), PW'(bw[N-1:0]));
    chk("mul_rst_low_in_clr", PW'(mul_rst), '0);
    chk("busy_in_clr", PW'(busy), PW'(1'b1));
  endtask

  task automatic wait_done(input int unsigned target);
    int unsigned n = 0;
    while (done_cnt < target) begin
      @(posedge clk); #1;
      n++;
      if (n > 5000) begin
        checks++; errors++;
        $display("FAIL product_timeout actual=%0d required=%0d", done_cnt, target);
        break;
      end
    end
  endtask

  task automatic take(output logic [PW-1:0] p);
    if (got_q.size() > 0) p = got_q.pop_front();
    else p = '1;
  endtask

  function automatic logic [NW*W-1:0] rnd_op();
    logic [NW*W-1:0] r;
    for (int k = 0; k < NW; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0]   p;
    logic [NW*W-1:0] ra;
    int unsigned     ndone = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", PW'(bus.in_ready), PW'(1'b1));
    chk("rst_mul_rst", PW'(mul_rst), '0);
    chk("rst_out_valid", PW'(bus.out_valid), '0);
    chk("rst_out_last", PW'(bus.out_last), '0);
    chk("rst_busy", PW'(busy), '0);
    chk("rst_mul_a", PW'(mul_a), '0);
    chk("rst_mul_b", PW'(mul_b), '0);
    rst = 1'b0;

    // 1 x 1
    load_op(192'd1, 192'd1, 1'b0);
    ndone++; wait_done(ndone); take(p);
    chk("one_by_one", p, PW'(1));

    // (2^163-1)^2 with garbage above bit 162 in words 5 and 11
    load_op('1, '1, 1'b0);
    ndone++; wait_done(ndone); take(p);
    chk("ones_w0", PW'(p[0 +: W]), PW'(32'h0000_0001));
    chk("ones_w4", PW'(p[4*W +: W]), PW'(32'h0000_0000));
    chk("ones_w5", PW'(p[5*W +: W]), PW'(32'hFFFF_FFF0));
    chk("ones_w10", PW'(p[10*W +: W]), PW'(32'h0000_003F));

    // random operands with input gaps and output stalls
    stall_mode = 1;
    for (int t = 0; t < 3; t++) begin
      load_op(rnd_op(), rnd_op(), 1'b1);
      ndone++;
    end
    wait_done(ndone);
    for (int t = 0; t < 3; t++) take(p);
    stall_mode = 0;

    // reset in the middle of WAIT (counter at 80)
    load_op(rnd_op(), rnd_op(), 1'b0);
    repeat (81) begin @(posedge clk); #1; end
    chk("mul_rst_released_in_wait", PW'(mul_rst), PW'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midwait_rst_in_ready", PW'(bus.in_ready), PW'(1'b1));
    chk("midwait_rst_mul_rst", PW'(mul_rst), '0);
    chk("midwait_rst_out_valid", PW'(bus.out_valid), '0);
    chk("midwait_rst_busy", PW'(busy), '0);
    chk("midwait_rst_mul_a", PW'(mul_a), '0);
    rst = 1'b0;
    repeat (200) begin @(posedge clk); #1; end
    load_op(192'd3, 192'd5, 1'b0);
    ndone++; wait_done(ndone); take(p);
    chk("after_rst_3x5_w0", PW'(p[0 +: W]), PW'(32'h0000_000F));
    chk("after_rst_3x5", p, PW'(15));

    // back-to-back products
    load_op(192'd7, 192'd9, 1'b0);
    load_op(192'hFFFF_FFFF, 192'd2, 1'b0);
    ndone += 2; wait_done(ndone);
    take(p);
    chk("b2b_7x9", p, PW'(63));
    take(p);
    chk("b2b_ffffffff_x2", p, PW'(64'h1_FFFF_FFFE));

    // zero times random
    ra = rnd_op();
    load_op('0, ra, 1'b0);
    ndone++; wait_done(ndone); take(p);
    chk("zero_product", p, '0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/schoolbook_ctrl.md
# schoolbook_ctrl

Word-serial front/back end for the 163x163 iterative schoolbook multiplier. It collects operands a and b as 32-bit words over a valid/ready stream and drives them onto the multiplier's parallel inputs. It also sequences the multiplier's active-low clear and waits out its fixed latency. Finally it captures the 326-bit product and streams it back as 32-bit words. It sits directly between the system bus adapter and the multiplier core, which is instantiated alongside it in the wrapper.

## Interface

Parameters:
- N, 163: operand width in bits (product width 2N).
- W, 32: stream word width.
- LAT, 165: WAIT cycles between multiplier clear release and product capture; the core's last product update occurs on its N+1-th enabled edge, and LAT = N+2 leaves one cycle of margin.

Ports:
- clk  input  1  clock; everything is on the rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- in_valid  input  1  operand word valid.
- in_ready  output  1  operand word accepted when in_valid & in_ready.
- in_data  input  W  operand word.
- mul_a  output  N  operand a to the multiplier.
- mul_b  output  N  operand b to the multiplier.
- mul_rst  output  1  multiplier clear, active-low (0 = clear).
- mul_c  input  2N  product from the multiplier.
- out_valid  output  1  product word valid.
- out_ready  input  1  product word consumed when out_valid & out_ready.
- out_data  output  W  product word.
- out_last  output  1  high with the final product word.
- busy  output  1  high in any state except LOAD.

## Operation

- NW = ceil(N/W) = 6 words per operand; NP = ceil(2N/W) = 11 product words.
- States are LOAD, CLR, WAIT and OUT. Reset enters LOAD with:
  - word counter 0, operand registers 0, product register 0;
  - in_ready=1, mul_rst=0, out_valid=0, out_last=0, busy=0.
- LOAD:
  - in_ready=1. Each accepted word is written to operand slice [k*W +: W]: words 0..5 go to a, words 6..11 go to b, least-significant word first.
  - Bits of word 5 and word 11 above bit N-1 (bits 3..31 of those words) are discarded.
  - After word 11 is accepted, go to CLR. in_ready drops in the same edge.
- CLR: one cycle, mul_rst=0. mul_a and mul_b already hold the new operands. Go to WAIT with the cycle counter at 0.
- WAIT:
  - mul_rst=1 and the counter increments every cycle.
  - On the cycle where counter==LAT-1, register mul_c into the product register and go to OUT with the word index at 0.
- OUT:
  - out_valid=1 and out_data = product[idx*W +: W], zero-extended above bit 2N-1 (word 10 carries bits 320..325 in bits 0..5).
  - out_last=1 when idx==NP-1.
  - On a handshake, idx increments. The handshake on the last word returns to LOAD with the word counter at 0.
- mul_rst stays 0 in LOAD and OUT, so the core is held cleared whenever it is not computing.
- Operands and product are held stable outside their loading and capture edges. out_data must not change while out_valid=1 and out_ready=0.
- Arithmetic is unsigned with no modular reduction.

## Timing

- Operand acceptance is at most one word per cycle, and there are no bubbles if in_valid is held high.
- Latency: the last operand handshake (edge E) is followed by 1 CLR cycle plus LAT WAIT cycles. out_valid first rises at edge E+1+LAT, i.e. 166 cycles after E.
- Output is at most one word per cycle. With out_ready held high, the 11 words take 11 cycles, and in_ready rises on the edge after the out_last handshake.
- Throughput with no stalls is 12 + 1 + 165 + 11 = 189 cycles per product.
- Reset asserted in any state, including mid-WAIT or mid-OUT, returns to LOAD on that edge and restores all reset values. A partially loaded operand set or partially streamed product is abandoned, and mul_rst=0 clears the core.
- in_valid is ignored outside LOAD. out_ready is ignored outside OUT.

## Test plan

- a=1, b=1 -> out words: 0x00000001, then 10 words of 0x00000000; out_last only on word 10; out_valid first at E+166.
- a=b=2^163-1, with word 5 and word 11 fed as 0xFFFFFFFF (garbage high bits) -> product (2^163-1)^2: word 0=0x00000001, word 10=0x0000003F, intermediate words match the reference model; the discarded high bits have no effect.
- Random a, b with random in_valid gaps and random out_ready stalls -> product equals a*b, and out_data is stable during every stall.
- Reset pulsed mid-WAIT (counter=80) -> LOAD, in_ready=1, mul_rst=0, out_valid=0. A fresh a=3, b=5 then yields word 0=0x0000000F.
- Back-to-back products (7x9, then 0xFFFFFFFF x 2) -> 63, then 0x1FFFFFFFE. No residue from the first result, since the core is re-cleared in CLR.
- a=0, b=random -> all 11 words zero; busy high from CLR through the last OUT handshake.
